// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter driving the mux4 select for a shared bus.
// Latency: request sampled in IDLE -> grant/select registered on the next edge;
//          release (done or dropped req) -> grant cleared on the same edge.
// Backpressure: none; an owner holds the bus until done, dropped req or watchdog.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high
//   req      request lines, bit i = requester i
//   done     owner finished its transfer (only looked at while granted)
//   grant    registered one-hot grant, zero when nobody owns the bus
//   select   index of current/last owner, steers mux4
//   busy     high while a grant is outstanding (|grant)
//   timeout  one-cycle pulse after the watchdog forced a release
module arb4_rr #(
  parameter int TIMEOUT  = 15,  // max hold cycles; 0 disables the watchdog
  parameter int CNT_BITS = 4    // 2**CNT_BITS must exceed TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       busy,
  output logic       timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;

  // Last counter value an owner may reach before the watchdog fires.
  localparam logic [CNT_BITS-1:0] CNT_LAST =
    (TIMEOUT > 0) ? CNT_BITS'(TIMEOUT - 1) : '0;

  logic [1:0]          state;
  logic [1:0]          last;    // most recent owner; lowest priority next time
  logic [CNT_BITS-1:0] cnt;

  logic [1:0] win;
  logic       win_vld;
  logic       rel;
  logic       wd_hit;

  // Rotating priority scan starting just after the last owner. The 2-bit
  // sum wraps naturally, so k=4 lands back on the last owner itself.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!win_vld && req[last + 2'(k)]) begin
        win     = last + 2'(k);
        win_vld = 1'b1;
      end
    end
  end

  assign rel    = done | ~req[last];
  assign wd_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      select  <= '0;
      last    <= 2'd3;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant  <= 4'b0001 << win;
            select <= win;
            last   <= win;
            cnt    <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          // A normal release takes precedence over the watchdog on the same
          // cycle, so no timeout pulse is raised in that case.
          if (rel) begin
            grant <= '0;
            state <= IDLE;
          end else if (wd_hit) begin
            grant   <= '0;
            timeout <= 1'b1;
            state   <= IDLE;
          end else if (TIMEOUT > 0) begin
            // Leaving at CNT_LAST means the counter never passes it.
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_arb4_rr.sv
module tb_arb4_rr;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] select;
  logic       busy;
  logic       timeout;

  arb4_rr #(.TIMEOUT(15), .CNT_BITS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .select  (select),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       t;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic rs, input logic [3:0] r, input logic d,
                      input logic [3:0] eg, input logic [1:0] es,
                      input logic et, input string nm);
    exp_t e;
    reset = rs;
    req   = r;
    done  = d;
    e.due = cyc + 1;
    e.g   = eg;
    e.s   = es;
    e.b   = |eg;
    e.t   = et;
    e.nm  = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares registered outputs mid-cycle against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        if (e.due < cyc) begin
          total++; bad++;
          $display("FAIL %s stale expectation due=%0d now=%0d", e.nm, e.due, cyc);
        end else begin
          total++;
          if (grant !== e.g) begin
            bad++;
            $display("FAIL %s grant got=%b want=%b cyc=%0d", e.nm, grant, e.g, cyc);
          end
          total++;
          if (select !== e.s) begin
            bad++;
            $display("FAIL %s select got=%0d want=%0d cyc=%0d", e.nm, select, e.s, cyc);
          end
          total++;
          if (busy !== e.b) begin
            bad++;
            $display("FAIL %s busy got=%b want=%b cyc=%0d", e.nm, busy, e.b, cyc);
          end
          total++;
          if (timeout !== e.t) begin
            bad++;
            $display("FAIL %s timeout got=%b want=%b cyc=%0d", e.nm, timeout, e.t, cyc);
          end
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "reset0");
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "reset1");

    // Single request, then done; select holds after release.
    step(0, 4'b0001, 0, 4'b0001, 2'd0, 0, "t1_grant");
    step(0, 4'b0001, 1, 4'b0000, 2'd0, 0, "t1_done");
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, "t1_idle");

    // All requesting with done every grant cycle: full rotation with dead cycles.
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "t2_reset");
    step(0, 4'b1111, 1, 4'b0001, 2'd0, 0, "t2_g0");
    step(0, 4'b1111, 1, 4'b0000, 2'd0, 0, "t2_d0");
    step(0, 4'b1111, 1, 4'b0010, 2'd1, 0, "t2_g1");
    step(0, 4'b1111, 1, 4'b0000, 2'd1, 0, "t2_d1");
    step(0, 4'b1111, 1, 4'b0100, 2'd2, 0, "t2_g2");
    step(0, 4'b1111, 1, 4'b0000, 2'd2, 0, "t2_d2");
    step(0, 4'b1111, 1, 4'b1000, 2'd3, 0, "t2_g3");
    step(0, 4'b1111, 1, 4'b0000, 2'd3, 0, "t2_d3");
    step(0, 4'b1111, 1, 4'b0001, 2'd0, 0, "t2_g0b");
    step(0, 4'b0000, 1, 4'b0000, 2'd0, 0, "t2_end");

    // With last=1, requester 3 beats 0; then 0 wins after 3 owned.
    step(0, 4'b0010, 0, 4'b0010, 2'd1, 0, "t3_set_last1");
    step(0, 4'b0010, 1, 4'b0000, 2'd1, 0, "t3_rel1");
    step(0, 4'b1001, 0, 4'b1000, 2'd3, 0, "t3_g3");
    step(0, 4'b1001, 1, 4'b0000, 2'd3, 0, "t3_rel3");
    step(0, 4'b1001, 0, 4'b0001, 2'd0, 0, "t3_g0");
    step(0, 4'b1001, 1, 4'b0000, 2'd0, 0, "t3_rel0");

    // Watchdog: owner 2 holds for exactly 15 cycles, then timeout pulse.
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "t4_grant");
    for (int i = 0; i < 14; i++)
      step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "t4_hold");
    step(0, 4'b0100, 0, 4'b0000, 2'd2, 1, "t4_timeout");
    step(0, 4'b0000, 0, 4'b0000, 2'd2, 0, "t4_pulse_end");

    // Done on the 15th cycle wins over watchdog; others requesting, no preemption.
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "t4b_grant");
    for (int i = 0; i < 14; i++)
      step(0, 4'b1111, 0, 4'b0100, 2'd2, 0, "t4b_hold");
    step(0, 4'b1111, 1, 4'b0000, 2'd2, 0, "t4b_done_at_limit");
    step(0, 4'b0000, 0, 4'b0000, 2'd2, 0, "t4b_idle");

    // Owner 1 drops its request mid-grant; done in IDLE is ignored.
    step(0, 4'b0010, 0, 4'b0010, 2'd1, 0, "t5_grant");
    step(0, 4'b0010, 0, 4'b0010, 2'd1, 0, "t5_hold");
    step(0, 4'b0000, 0, 4'b0000, 2'd1, 0, "t5_drop");
    step(0, 4'b0000, 1, 4'b0000, 2'd1, 0, "t5_done_idle");

    // Reset mid-grant at counter 7, then last=3 so requester 1 wins 0110.
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "t6_grant");
    for (int i = 0; i < 7; i++)
      step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "t6_hold");
    step(1, 4'b0100, 0, 4'b0000, 2'd0, 0, "t6_reset");
    step(0, 4'b0110, 0, 4'b0010, 2'd1, 0, "t6_regrant");
    step(0, 4'b0110, 1, 4'b0000, 2'd1, 0, "t6_rel");

    // Reset on the watchdog edge cancels the timeout pulse.
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "t7_grant");
    for (int i = 0; i < 14; i++)
      step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "t7_hold");
    step(1, 4'b0100, 0, 4'b0000, 2'd0, 0, "t7_reset_at_limit");
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, "t7_after");

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #1;
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
